// File: rtl/traffic_light_monitor.sv
// Passive run-time checker for a RED->GREEN->YELLOW traffic light: flags non-one-hot
// lamp patterns, out-of-order phases and wrong phase dwell, and counts completed cycles.
module traffic_light_monitor #(
    parameter int RED_TIME    = 5,
    parameter int GREEN_TIME  = 5,
    parameter int YELLOW_TIME = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    output logic [1:0]       phase,
    output logic             err_pattern,
    output logic             err_order,
    output logic             err_dwell,
    output logic             err_any,
    output logic [CNT_W-1:0] cycles
);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        RED    = 2'd1,
        GREEN  = 2'd2,
        YELLOW = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] R_T       = CNT_W'(RED_TIME);
    localparam logic [CNT_W-1:0] G_T       = CNT_W'(GREEN_TIME);
    localparam logic [CNT_W-1:0] Y_T       = CNT_W'(YELLOW_TIME);
    localparam logic [CNT_W-1:0] DWELL_MAX = '1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   dwell_q, dwell_d;
    logic               partial_q, partial_d;
    logic               err_pattern_q, err_pattern_d;
    logic               err_order_q, err_order_d;
    logic               err_dwell_q, err_dwell_d;
    logic               err_any_q, err_any_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;

    logic               legal;
    state_t             pat;
    state_t             succ;
    logic [CNT_W-1:0]   t_cur;

    always_comb begin
        legal = 1'b1;
        pat   = SYNC;
        case ({red, yellow, green})
            3'b100:  pat = RED;
            3'b001:  pat = GREEN;
            3'b010:  pat = YELLOW;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        t_cur = DWELL_MAX;
        succ  = SYNC;
        case (state_q)
            RED:     begin t_cur = R_T; succ = GREEN;  end
            GREEN:   begin t_cur = G_T; succ = YELLOW; end
            YELLOW:  begin t_cur = Y_T; succ = RED;    end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        dwell_d       = dwell_q;
        partial_d     = partial_q;
        err_pattern_d = 1'b0;
        err_order_d   = 1'b0;
        err_dwell_d   = 1'b0;
        cycles_d      = cycles_q;

        if (!legal) begin
            // Abandoned phase gets no dwell check; resynchronise on the next legal lamp.
            err_pattern_d = 1'b1;
            state_d       = SYNC;
            dwell_d       = '0;
            partial_d     = 1'b0;
        end else if (state_q == SYNC) begin
            state_d   = pat;
            dwell_d   = CNT_W'(1);
            partial_d = 1'b1;
        end else if (pat == state_q) begin
            if (dwell_q != DWELL_MAX) dwell_d = dwell_q + CNT_W'(1);
            // Only the step onto T+1 pulses, so a held phase reports overlong once.
            err_dwell_d = (dwell_q == t_cur);
        end else begin
            err_dwell_d = !partial_q && (dwell_q < t_cur);
            err_order_d = (pat != succ);
            if (state_q == YELLOW && pat == RED) cycles_d = cycles_q + CNT_W'(1);
            state_d   = pat;
            dwell_d   = CNT_W'(1);
            partial_d = 1'b0;
        end

        err_any_d = err_any_q | err_pattern_d | err_order_d | err_dwell_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= SYNC;
            dwell_q       <= '0;
            partial_q     <= 1'b0;
            err_pattern_q <= 1'b0;
            err_order_q   <= 1'b0;
            err_dwell_q   <= 1'b0;
            err_any_q     <= 1'b0;
            cycles_q      <= '0;
        end else begin
            state_q       <= state_d;
            dwell_q       <= dwell_d;
            partial_q     <= partial_d;
            err_pattern_q <= err_pattern_d;
            err_order_q   <= err_order_d;
            err_dwell_q   <= err_dwell_d;
            err_any_q     <= err_any_d;
            cycles_q      <= cycles_d;
        end
    end

    assign phase       = state_q;
    assign err_pattern = err_pattern_q;
    assign err_order   = err_order_q;
    assign err_dwell   = err_dwell_q;
    assign err_any     = err_any_q;
    assign cycles      = cycles_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: vector table on a default instance,
// plus a cycle-counter wrap sequence on a CNT_W=3 instance.
module tb_traffic_light_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic       rst_a, r_a, y_a, g_a;
    logic [1:0] ph_a;
    logic       ep_a, eo_a, ed_a, ea_a;
    logic [7:0] cyc_a;

    traffic_light_monitor dut_a (
        .clk(clk), .reset(rst_a), .red(r_a), .yellow(y_a), .green(g_a),
        .phase(ph_a), .err_pattern(ep_a), .err_order(eo_a), .err_dwell(ed_a),
        .err_any(ea_a), .cycles(cyc_a)
    );

    // Instance B: narrow counters for the wrap check
    logic       rst_b, r_b, y_b, g_b;
    logic [1:0] ph_b;
    logic       ep_b, eo_b, ed_b, ea_b;
    logic [2:0] cyc_b;

    traffic_light_monitor #(.CNT_W(3)) dut_b (
        .clk(clk), .reset(rst_b), .red(r_b), .yellow(y_b), .green(g_b),
        .phase(ph_b), .err_pattern(ep_b), .err_order(eo_b), .err_dwell(ed_b),
        .err_any(ea_b), .cycles(cyc_b)
    );

    typedef struct {
        logic       rst;
        logic [2:0] lamps;  // {red, yellow, green}
        int         n;      // cycles to hold; expectation checked after each
        logic [1:0] ph;
        logic [2:0] errs;   // {pattern, order, dwell}
        logic       any;
        logic [7:0] cyc;
    } vec_t;

    localparam logic [2:0] LR = 3'b100, LY = 3'b010, LG = 3'b001;

    vec_t tbl[$];
    int   passed = 0;
    int   total  = 0;

    function automatic vec_t mk(logic rst, logic [2:0] lamps, int n, logic [1:0] ph,
                                logic [2:0] errs, logic any, logic [7:0] cyc);
        vec_t v;
        v.rst = rst; v.lamps = lamps; v.n = n; v.ph = ph;
        v.errs = errs; v.any = any; v.cyc = cyc;
        return v;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        rst_a = 1'b1; {r_a, y_a, g_a} = 3'b000;
        rst_b = 1'b1; {r_b, y_b, g_b} = 3'b000;

        // Reset state
        tbl.push_back(mk(1, 3'b000, 1, 0, 3'b000, 0, 0));
        // Clean sequence
        tbl.push_back(mk(0, LR, 5, 1, 3'b000, 0, 0));
        tbl.push_back(mk(0, LG, 5, 2, 3'b000, 0, 0));
        tbl.push_back(mk(0, LY, 2, 3, 3'b000, 0, 0));
        tbl.push_back(mk(0, LR, 5, 1, 3'b000, 0, 1));
        tbl.push_back(mk(0, LG, 5, 2, 3'b000, 0, 1));
        tbl.push_back(mk(0, LY, 2, 3, 3'b000, 0, 1));
        tbl.push_back(mk(0, LR, 1, 1, 3'b000, 0, 2));
        tbl.push_back(mk(0, LR, 4, 1, 3'b000, 0, 2));
        // Overlong GREEN: pulse after the 6th sample only
        tbl.push_back(mk(0, LG, 5, 2, 3'b000, 0, 2));
        tbl.push_back(mk(0, LG, 1, 2, 3'b001, 1, 2));
        tbl.push_back(mk(0, LG, 1, 2, 3'b000, 1, 2));
        // Reset mid-GREEN after an error clears everything
        tbl.push_back(mk(1, LG, 1, 0, 3'b000, 0, 0));
        // Short YELLOW followed by GREEN: dwell and order together
        tbl.push_back(mk(0, LR, 5, 1, 3'b000, 0, 0));
        tbl.push_back(mk(0, LG, 5, 2, 3'b000, 0, 0));
        tbl.push_back(mk(0, LY, 1, 3, 3'b000, 0, 0));
        tbl.push_back(mk(0, LG, 1, 2, 3'b011, 1, 0));
        tbl.push_back(mk(0, LG, 4, 2, 3'b000, 1, 0));
        // Illegal pattern then resync on a partial RED
        tbl.push_back(mk(0, 3'b101, 1, 0, 3'b100, 1, 0));
        tbl.push_back(mk(0, LR, 3, 1, 3'b000, 1, 0));
        tbl.push_back(mk(0, LG, 1, 2, 3'b000, 1, 0));
        // Illegal patterns while in SYNC, entry into YELLOW, legal Y->R counts
        tbl.push_back(mk(1, 3'b000, 1, 0, 3'b000, 0, 0));
        tbl.push_back(mk(0, 3'b000, 1, 0, 3'b100, 1, 0));
        tbl.push_back(mk(0, 3'b111, 1, 0, 3'b100, 1, 0));
        tbl.push_back(mk(0, 3'b110, 1, 0, 3'b100, 1, 0));
        tbl.push_back(mk(0, LY, 1, 3, 3'b000, 1, 0));
        tbl.push_back(mk(0, LR, 1, 1, 3'b000, 1, 1));
        // Short RED with legal successor: dwell only
        tbl.push_back(mk(0, LG, 1, 2, 3'b001, 1, 1));
        // Overlong YELLOW then out-of-order RED->... YELLOW->GREEN with no short
        tbl.push_back(mk(0, LG, 4, 2, 3'b000, 1, 1));
        tbl.push_back(mk(0, LY, 2, 3, 3'b000, 1, 1));
        tbl.push_back(mk(0, LY, 1, 3, 3'b001, 1, 1));
        tbl.push_back(mk(0, LG, 1, 2, 3'b010, 1, 1));
        // GREEN->RED: order error, no cycle count
        tbl.push_back(mk(0, LG, 4, 2, 3'b000, 1, 1));
        tbl.push_back(mk(0, LR, 1, 1, 3'b010, 1, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                rst_a = tbl[i].rst;
                {r_a, y_a, g_a} = tbl[i].lamps;
                @(posedge clk); #1;
                check($sformatf("row%0d.%0d phase", i, k), 16'(ph_a), 16'(tbl[i].ph));
                check($sformatf("row%0d.%0d errs", i, k), 16'({ep_a, eo_a, ed_a}), 16'(tbl[i].errs));
                check($sformatf("row%0d.%0d any", i, k), 16'(ea_a), 16'(tbl[i].any));
                check($sformatf("row%0d.%0d cycles", i, k), 16'(cyc_a), 16'(tbl[i].cyc));
            end
        end

        // Counter wrap on CNT_W=3: eight clean cycles bring cycles back to 0
        rst_b = 1'b1;
        @(posedge clk); #1;
        check("wrap reset cycles", 16'(cyc_b), 16'd0);
        rst_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int s = 0; s < 12; s++) begin
                {r_b, y_b, g_b} = (s < 5) ? LR : (s < 10) ? LG : LY;
                @(posedge clk); #1;
                check($sformatf("wrap%0d.%0d cycles", k, s), 16'(cyc_b), 16'(k));
                check($sformatf("wrap%0d.%0d errs", k, s), 16'({ep_b, eo_b, ed_b, ea_b}), 16'd0);
            end
        end
        {r_b, y_b, g_b} = LR;
        @(posedge clk); #1;
        check("wrap final cycles", 16'(cyc_b), 16'd0);
        check("wrap final phase", 16'(ph_b), 16'd1);
        check("wrap final errs", 16'({ep_b, eo_b, ed_b, ea_b}), 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker on the receiving end of the `traffic_light_controller` light outputs. It samples `red`/`yellow`/`green` every clock and checks three things:
- the pattern is one-hot;
- phases follow RED -> GREEN -> YELLOW -> RED;
- each phase lasts exactly its programmed number of cycles.

It reports the decoded phase, per-violation pulses, a sticky error flag and a completed-cycle count. It sits beside the controller in benches and in system builds as a run-time safety monitor.

## Interface
Parameters:
- `RED_TIME`, 5, required RED dwell in clock cycles (>=1)
- `GREEN_TIME`, 5, required GREEN dwell in clock cycles (>=1)
- `YELLOW_TIME`, 2, required YELLOW dwell in clock cycles (>=1)
- `CNT_W`, 8, width of dwell and cycle counters; every *_TIME <= 2^CNT_W-2

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `red`  in  1  observed red lamp
- `yellow`  in  1  observed yellow lamp
- `green`  in  1  observed green lamp
- `phase`  out  2  decoded phase: 0 = SYNC/none, 1 = RED, 2 = GREEN, 3 = YELLOW
- `err_pattern`  out  1  one-cycle pulse: non-one-hot input (000, 011, 101, 110, 111)
- `err_order`  out  1  one-cycle pulse: legal-pattern transition to a non-successor phase
- `err_dwell`  out  1  one-cycle pulse: phase too long or too short
- `err_any`  out  1  sticky OR of all error pulses since reset
- `cycles`  out  CNT_W  count of completed YELLOW->RED transitions; wraps modulo 2^CNT_W

## Operation
- Reset is synchronous, active-high and one clock and one reset only. While `reset`=1 at a rising edge:
  - all outputs go to 0;
  - state goes to SYNC;
  - the dwell counter and the partial flag clear.
- State machine: SYNC, RED, GREEN, YELLOW. `phase` encodes the current state.
- **In SYNC:**
  - A legal one-hot pattern enters the matching phase with dwell = 1 and partial = 1.
  - An illegal pattern pulses `err_pattern` and stays in SYNC.
  - No order or dwell check is made on the entry transition.
- **Same pattern as the current phase:**
  - dwell increments, saturating at 2^CNT_W-1.
  - When dwell reaches T+1 (T = that phase's *_TIME), pulse `err_dwell` once. No further pulses while the phase is held.
  - This overlong check applies even when partial = 1.
- **Different legal pattern (phase exit):**
  - If partial = 0 and dwell < T, pulse `err_dwell` (short phase).
  - If the new phase is not the successor (RED->GREEN, GREEN->YELLOW, YELLOW->RED), pulse `err_order`.
  - Enter the new phase with dwell = 1 and partial = 0 regardless of errors, so the order check tracks the actual lamp.
  - A legal YELLOW->RED transition increments `cycles`, whether or not there were dwell errors.
- **Illegal pattern in any phase:**
  - pulse `err_pattern`;
  - go to SYNC, `phase` = 0;
  - no dwell check is made on the abandoned phase.
- **Simultaneous events:** `err_dwell` (short) and `err_order` may pulse in the same cycle. `err_pattern` never coincides with the other two.
- `err_any` is set in the cycle any pulse is asserted and clears only on reset.

## Timing
- All outputs are registered.
- Latency is 1: inputs sampled at rising edge N are reflected in the outputs immediately after edge N, i.e. visible during cycle N+1.
- Error pulses are exactly one cycle wide. `err_any` rises in the same cycle as the first pulse.
- Dwell counting: the first sample of a phase counts as 1. A correct phase is exactly T consecutive samples.
- Overlong `err_dwell` is asserted in the cycle after the (T+1)th consecutive sample.
- Short `err_dwell` is asserted in the cycle after the first sample of the next phase.
- Reset mid-phase: the next cycle shows all outputs 0, including a cleared `err_any`. Normal checking resumes from SYNC on the next edge with `reset`=0.
- No handshakes; inputs are assumed synchronous to `clk`.

## Test plan
- **Clean sequence.** Reset 1 cycle, then RED x5, GREEN x5, YELLOW x2, RED x5, GREEN x5, YELLOW x2, RED x1 -> `phase` follows 1, 2, 3, 1; no error pulses; `err_any`=0; `cycles`=1 after the first YELLOW->RED and 2 after the second.
- **Overlong GREEN.** After a clean RED x5, drive GREEN x7 -> `err_dwell`=1 for exactly one cycle, after the 6th GREEN sample; `err_any`=1 from then on; `phase` stays 2.
- **Wrong order, short YELLOW.** After clean RED x5 and GREEN x5, drive YELLOW x1 then GREEN -> `err_dwell` and `err_order` both pulse in the same cycle; `phase`=2; `cycles` unchanged.
- **Illegal pattern and resync.** In GREEN, drive red=1, green=1 for one cycle, then RED x3, then GREEN -> `err_pattern` pulse and `phase`=0. RED is entered as partial, so no short-dwell error on the RED x3. GREEN then follows with no error.
- **Reset mid-phase.** After an error, assert `reset` for 1 cycle during GREEN -> next cycle `phase`=0, `cycles`=0, `err_any`=0, all pulses 0.
- **Counter wrap.** With CNT_W=3 (and *_TIME defaults <= 6), run 8 clean cycles -> `cycles` returns to 0 with no error pulses.
